// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared up-counter timer serving NREQ requesters.
// Round-robin arbitration picks an owner, the owner's delay is latched, the
// counter runs from 0 up to that delay, and done is pulsed back to the owner.
// Optional feature: define TIMER_ARB_ABORT_EN to add the per-requester abort
// input, which cancels the owner's run without a done pulse.
module timer_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] delay,
`ifdef TIMER_ARB_ABORT_EN
  input  logic [NREQ-1:0]   abort,
`endif
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [N-1:0]  target;
  logic [IW-1:0] winner;
  logic          winner_found;
  logic          at_target;
  logic          abort_hit;

  assign at_target = (count == target);

  // Cancel request from the current owner; non-owner bits are ignored and
  // only LOAD and RUN can be cut short.
`ifdef TIMER_ARB_ABORT_EN
  assign abort_hit = abort[owner] && ((state == LOAD) || (state == RUN));
`else
  assign abort_hit = 1'b0;
`endif

  // Round-robin search: first set req bit starting just after the last owner.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    winner       = last;
    winner_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last) + k) % NREQ;
      if (!winner_found && req[idx]) begin
        winner_found = 1'b1;
        winner       = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (winner_found) state_next = LOAD;
      LOAD: state_next = abort_hit ? IDLE : RUN;
      RUN: begin
        if (abort_hit)      state_next = IDLE;
        else if (at_target) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Timer datapath: owner/target capture, counter, and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= '0;
      target <= '0;
      last   <= IW'(NREQ - 1);
      count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          count <= '0;
          if (winner_found) begin
            owner  <= winner;
            target <= delay[int'(winner)*N +: N];
          end
        end
        LOAD: begin
          count <= '0;
          if (abort_hit) last <= owner;
        end
        RUN: begin
          if (abort_hit) begin
            count <= '0;
            last  <= owner;
          end else if (!at_target) begin
            // Equality stop means the counter never wraps, even at all-ones.
            count <= count + N'(1);
          end
        end
        DONE: begin
          count <= '0;
          last  <= owner;
        end
        default: count <= '0;
      endcase
    end
  end

  // Moore outputs decoded from state and the latched owner.
  always_comb begin
    grant = '0;
    done  = '0;
    busy  = (state != IDLE);
    if (state == LOAD) grant[owner] = 1'b1;
    if (state == DONE) done[owner]  = 1'b1;
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed self-checking bench for timer_arbiter with
// N=4, NREQ=4. Inputs are driven and outputs sampled on the falling edge.
module tb_timer_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] delay;
`ifdef TIMER_ARB_ABORT_EN
  logic [NREQ-1:0]   abort;
`endif
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [N-1:0]      count;

  int errors  = 0;
  int checks  = 0;
  bit running = 1'b1;

  timer_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .delay (delay),
`ifdef TIMER_ARB_ABORT_EN
    .abort (abort),
`endif
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
`ifdef TIMER_ARB_ABORT_EN
    abort = '0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Tick until some grant bit is high, giving up after budget cycles.
  task automatic wait_grant(input int budget, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (grant == '0 && waited < budget);
    if (grant == '0) check("grant_timeout", 32'd1, 32'd0);
  endtask

  // One isolated request: grant, count 0..d, done d+2 after grant, then idle.
  task automatic run_one(input int idx, input int d);
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    delay[idx*N +: N] = N'(d);
    req = onehot;
    tick();
    check("grant", grant, onehot);
    check("busy_load", busy, 1);
    req = '0;
    for (int j = 0; j <= d; j++) begin
      tick();
      check("run_count", count, j);
      check("run_nodone", done, 0);
      check("run_busy", busy, 1);
    end
    tick();
    check("done", done, onehot);
    check("done_count", count, d);
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_count", count, 0);
  endtask

  // Protocol invariant: grant and done are each at most one-hot and never overlap.
  always @(negedge clk) begin
    if (running && reset === 1'b0)
      check("onehot_excl",
            ($countones(grant) > 1) || ($countones(done) > 1) || ((grant != 0) && (done != 0)),
            0);
  end

  initial begin
    int w;
    reset = 1'b1;
    req   = '0;
    delay = '0;
`ifdef TIMER_ARB_ABORT_EN
    abort = '0;
`endif
    tick();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    tick();
    reset = 1'b0;

    run_one(0, 3);   // single request
    run_one(2, 0);   // zero delay
    run_one(1, 15);  // maximum delay for N=4, no wrap

    // Round-robin fairness with all requests held.
    do_reset();
    for (int i = 0; i < NREQ; i++) delay[i*N +: N] = N'(1);
    req = '1;
    for (int g = 0; g < 5; g++) begin
      logic [NREQ-1:0] exp_g;
      wait_grant(20, w);
      exp_g = '0;
      exp_g[g % NREQ] = 1'b1;
      check("rr_owner", grant, exp_g);
      check(g == 0 ? "rr_latency" : "rr_gap", w, g == 0 ? 1 : 5);
    end
    req = '0;

    // Reset in the middle of a run.
    do_reset();
    delay[0 +: N] = N'(10);
    req = 4'b0001;
    tick();
    check("mid_grant", grant, 4'b0001);
    req = '0;
    repeat (5) tick();
    check("mid_count4", count, 4);
    reset = 1'b1;
    #1;
    check("mid_async_count", count, 0);
    check("mid_async_busy", busy, 0);
    tick();
    reset = 1'b0;
    repeat (14) begin
      tick();
      check("mid_nodone", done, 0);
    end
    req = 4'b1000;
    tick();
    check("post_rst_req3", grant, 4'b1000);
    do_reset();
    req = 4'b1001;
    tick();
    check("post_rst_req0_first", grant, 4'b0001);
    req = '0;

`ifdef TIMER_ARB_ABORT_EN
    // Owner abort, pending request picked up afterwards; non-owner abort ignored.
    do_reset();
    delay[1*N +: N] = N'(8);
    delay[2*N +: N] = N'(1);
    req = 4'b0110;
    tick();
    check("ab_grant1", grant, 4'b0010);
    req = 4'b0100;
    repeat (3) tick();
    check("ab_count2", count, 2);
    abort = 4'b0010;
    tick();
    abort = '0;
    check("ab_idle_busy", busy, 0);
    check("ab_idle_count", count, 0);
    check("ab_nodone", done, 0);
    tick();
    check("ab_grant2", grant, 4'b0100);
    req = '0;
    tick();
    abort = 4'b0001;
    tick();
    abort = '0;
    check("ab_other_busy", busy, 1);
    check("ab_other_count", count, 1);
    tick();
    check("ab_other_done", done, 4'b0100);
`endif

    tick();
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares one free-running-style up-counter timer between `NREQ` requesters. Each requester asks for a delay of `D` clock cycles. The block arbitrates round-robin, loads the shared counter, and runs it until the count equals `D`. It then pulses `done` back to the owning requester. It sits between the counter/adder/comparator timer datapath and the blocks that need timeouts, replacing per-client timer copies.

## Interface
- `N`, 16, counter and delay width in bits.
- `NREQ`, 4, number of requesters (2..16).
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req`  in  `NREQ`  level request, one bit per requester.
- `delay`  in  `NREQ*N`  flat delay bus; requester i uses bits `[i*N +: N]`; must be stable while `req[i]` is high.
- `grant`  out  `NREQ`  one-hot, one-cycle pulse: request accepted, delay latched.
- `done`  out  `NREQ`  one-hot, one-cycle pulse: owner's delay expired.
- `busy`  out  1  high whenever state ≠ IDLE.
- `count`  out  `N`  current shared counter value.
- `abort`  in  `NREQ`  per-requester cancel; present only with `TIMER_ARB_ABORT_EN`.

## Operation
- **FSM states:** IDLE, LOAD, RUN, DONE. All outputs are registered or Moore-decoded from state.
- **IDLE:**
  - `count` holds at 0.
  - If any `req` bit is high, latch `owner` = round-robin winner and `target` = `delay[owner]`, then go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD:** `grant[owner]`=1 and `count`=0. Go to RUN.
- **RUN:**
  - If `count == target`, go to DONE (`count` holds).
  - Otherwise `count <= count + 1`.
- **DONE:**
  - `done[owner]`=1.
  - Set `last <= owner`, clear `count` to 0, go to IDLE.
- **Round-robin:**
  - The search starts at `last+1` and wraps modulo `NREQ`.
  - The first set `req` bit wins.
  - `last` resets to `NREQ-1`, so requester 0 wins the first arbitration.
- **Requester rule:**
  - Deassert `req[i]` in the cycle after `grant[i]`.
  - If `req[i]` is still high when the FSM returns to IDLE, it is treated as a new request.
  - Requests raised while busy are not lost; they are sampled in the next IDLE cycle.
- **Arithmetic:**
  - `count` is `N` bits, unsigned.
  - The equality stop prevents wrap-around, so `D = 2^N-1` is legal and runs to all-ones.
- **D = 0:** RUN sees `count == 0 == target` in its first cycle, and `done` follows.
- **Request changes:** a `req` drop after the IDLE sample does not affect the owner's run. `delay` changes after latching are ignored.
- **Reset:**
  - Reset at any time returns to IDLE on the next evaluation.
  - No `done` is emitted for an interrupted run.
  - `last` returns to `NREQ-1`.
- **Reset values:** `grant`=0, `done`=0, `busy`=0, `count`=0, state=IDLE.

## Timing
- The edge that samples `req` in IDLE is edge k.
- `grant` is high in the cycle after edge k.
- RUN occupies `D+1` cycles, with `count` = 0..D.
- `done` pulses exactly `D+2` cycles after the `grant` cycle.
- Minimum request-to-grant latency is 1 cycle. Minimum turnaround between consecutive runs is 1 IDLE cycle, so back-to-back grants are `D+4` cycles apart.
- `grant` and `done` are never high in the same cycle. At most one bit of each is high.
- `busy` rises with LOAD and falls in the IDLE cycle after DONE.

## Configuration
- **Macro:** `TIMER_ARB_ABORT_EN`.
- **Defined:**
  - The `abort` port exists.
  - `abort[owner]` sampled high in LOAD or RUN sends the FSM to IDLE at the next edge.
  - `count` clears to 0, `last <= owner`, and no `done` is emitted.
  - `abort` bits of non-owners are ignored.
- **Undefined:** no `abort` port. Every granted run completes with `done`.

## Test plan
- **Single request:** reset for 2 cycles, then `req[0]`=1 with `delay[0]`=3 → `grant[0]` at cycle c, `count` 0,1,2,3, `done[0]` at c+5, `busy` low at c+6.
- **Zero delay:** `req[2]`=1 with `delay[2]`=0 → `done[2]` exactly 2 cycles after `grant[2]`.
- **Round-robin fairness:** all four `req` held continuously with every delay 1 → grants in order 0,1,2,3,0, spaced 5 cycles apart.
- **Maximum delay:** `N`=4, `delay`=15 → `count` reaches 15 with no wrap, `done` 17 cycles after `grant`.
- **Reset mid-run:** `delay`=10, reset asserted when `count`=4 → `count`=0, `busy`=0, no `done` pulse. A new `req[3]` after reset is granted before `req[0]` only if `req[0]` is low.
- **Abort (`TIMER_ARB_ABORT_EN`):** `req[1]` with `delay`=8, `abort[1]` pulsed at `count`=2 → IDLE next cycle, no `done[1]`. A pending `req[2]` is granted 2 cycles after the abort.
